// File: rtl/anim_sequencer.sv
// Seven-segment animation frame generator: turns button pulses into mode/speed/pause
// state and steps a registered pattern. Optional macro: ANIM_SINGLE_STEP_EN.
module anim_sequencer #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_pulse,
  input  logic       speed_pulse,
  input  logic       pause_pulse,
  output logic [6:0] seg_out,
  output logic       frame_strobe,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {SPIN, FILL, SNAKE, BLINK} mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    beat_q, beat_d;
  logic [2:0]    idx_q, idx_d;
  mode_e         mode_q, mode_d;
  logic [1:0]    speed_q, speed_d;
  logic          paused_q, paused_d;
  logic [6:0]    seg_q, seg_d;
  logic          strobe_q, strobe_d;
  logic          tick, advance;
  logic [2:0]    beat_last;

  function automatic logic [2:0] next_idx(mode_e m, logic [2:0] i);
    logic [2:0] last;
    case (m)
      SPIN:    last = 3'd5;
      FILL:    last = 3'd6;
      SNAKE:   last = 3'd7;
      default: last = 3'd1;
    endcase
    return (i == last) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [6:0] pattern(mode_e m, logic [2:0] i);
    logic [6:0] p;
    p = 7'h00;
    case (m)
      SPIN: case (i)
        3'd0: p = 7'h01;  3'd1: p = 7'h02;  3'd2: p = 7'h04;
        3'd3: p = 7'h08;  3'd4: p = 7'h10;  3'd5: p = 7'h20;
        default: p = 7'h00;
      endcase
      FILL: case (i)
        3'd0: p = 7'h01;  3'd1: p = 7'h03;  3'd2: p = 7'h07;
        3'd3: p = 7'h0F;  3'd4: p = 7'h1F;  3'd5: p = 7'h3F;
        default: p = 7'h00;
      endcase
      SNAKE: case (i)
        3'd0: p = 7'h01;  3'd1: p = 7'h02;  3'd2: p = 7'h40;  3'd3: p = 7'h10;
        3'd4: p = 7'h08;  3'd5: p = 7'h04;  3'd6: p = 7'h40;  default: p = 7'h20;
      endcase
      default: p = (i == 3'd0) ? 7'h7F : 7'h00;
    endcase
    return p;
  endfunction

  assign beat_last = 3'((4'd8 >> speed_q) - 4'd1);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    presc_d  = presc_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    strobe_d = 1'b0;
    tick     = (presc_q == PRESC_MAX);
    advance  = !paused_q && tick && (beat_q == beat_last);

    if (!paused_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) beat_d = advance ? 3'd0 : beat_q + 3'd1;
      if (advance) begin
        idx_d    = next_idx(mode_q, idx_q);
        strobe_d = 1'b1;
      end
    end

`ifdef ANIM_SINGLE_STEP_EN
    if (speed_pulse && paused_q) begin
      idx_d    = next_idx(mode_q, idx_q);
      strobe_d = 1'b1;
    end else
`endif
    if (speed_pulse) begin
      speed_d = speed_q + 2'd1;
      presc_d = '0;
      beat_d  = 3'd0;
    end

    // Mode change is applied last so it overrides any coincident frame step.
    if (mode_pulse) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      idx_d    = 3'd0;
      presc_d  = '0;
      beat_d   = 3'd0;
      strobe_d = 1'b1;
    end

    if (pause_pulse) paused_d = !paused_q;

    seg_d = pattern(mode_d, idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      beat_q   <= 3'd0;
      idx_q    <= 3'd0;
      mode_q   <= SPIN;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
      seg_q    <= 7'h01;
      strobe_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      seg_q    <= seg_d;
      strobe_q <= strobe_d;
    end
  end

  assign seg_out      = seg_q;
  assign frame_strobe = strobe_q;
  assign mode         = mode_q;
  assign speed        = speed_q;
  assign paused       = paused_q;

endmodule
